ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter, the send side paired with the PS/2 receiver on the same clock/data pair.
- Takes a byte over a valid/ready handshake and runs the host request-to-send sequence: inhibit, start, 8 data bits LSB first, odd parity, stop, and device ACK.
- Runs on system clock ck and oversamples the PS/2 lines.
- Drives the open-drain lines through active-high pull-low enables.

---
 rtl/ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10-bit serial frame and device ACK.
// Define PS2_TX_GLITCH_FILTER_EN to require 4 identical synced clock samples before a level change counts.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES    = 5000,
    parameter int START_HOLD_CYCLES = 16,
    parameter int TIMEOUT_CYCLES    = 750000
) (
    input  logic       ck,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    localparam int PH_MAX = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int PW = $clog2(PH_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] INH_LAST   = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] START_LAST = PW'(START_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_DONE_WAIT = 3'd5
    } state_e;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_e          state_q, state_d;
    logic [PW-1:0]   ph_cnt_q, ph_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [9:0]      frame_q, frame_d;
    logic            clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d, ack_err_q, ack_err_d, timeout_q, timeout_d;
    logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic            clk_lvl_s, fall_s, timeout_s, timed_state_s;

    // Two-flop synchronizers and previous-level register for edge detection.
    always_comb begin
        clk_s1_d   = ps2_clk_in;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_dat_in;
        dat_s2_d   = dat_s1_q;
        clk_prev_d = clk_lvl_s;
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic       clk_filt_q, clk_filt_d;
    logic [1:0] filt_cnt_q, filt_cnt_d;

    // Level changes only after four consecutive differing samples.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = 2'd0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == 2'd3) begin
                clk_filt_d = clk_s2_q;
                filt_cnt_d = 2'd0;
            end else begin
                filt_cnt_d = filt_cnt_q + 2'd1;
            end
        end else begin
            filt_cnt_d = 2'd0;
        end
    end

    // Glitch filter registers.
    always_ff @(posedge ck) begin
        if (!reset) begin
            clk_filt_q <= 1'b0;
            filt_cnt_q <= 2'd0;
        end else begin
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign clk_lvl_s = clk_filt_q;
`else
    assign clk_lvl_s = clk_s2_q;
`endif

    assign fall_s        = clk_prev_q & ~clk_lvl_s;
    assign timeout_s     = (to_cnt_q == TO_LAST);
    assign timed_state_s = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_DONE_WAIT);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    frame_d  = {1'b1, odd_parity(tx_data), tx_data};
                    ph_cnt_d = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INHIBIT: begin
                if (ph_cnt_q == INH_LAST) begin
                    ph_cnt_d = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_START;
                end else begin
                    ph_cnt_d = ph_cnt_q + PW'(1);
                end
            end
            S_START: begin
                to_cnt_d = '0;
                if (ph_cnt_q == START_LAST) begin
                    clk_oe_d  = 1'b0;
                    bit_idx_d = 4'd0;
                    state_d   = S_SEND;
                end else begin
                    ph_cnt_d = ph_cnt_q + PW'(1);
                end
            end
            S_SEND: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (fall_s) begin
                    dat_oe_d = ~frame_q[bit_idx_q];
                    if (bit_idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    dat_oe_d = dat_oe_q;
                end
            end
            S_ACK: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (fall_s) begin
                    if (!dat_s2_q) begin
                        state_d = S_DONE_WAIT;
                    end else begin
                        ack_err_d = 1'b1;
                        dat_oe_d  = 1'b0;
                        state_d   = S_IDLE;
                    end
                end else begin
                    state_d = S_ACK;
                end
            end
            S_DONE_WAIT: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (clk_lvl_s && dat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE_WAIT;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
        // Timeout overrides any ACK decision made on the same cycle.
        if (timed_state_s && timeout_s) begin
            state_d   = S_IDLE;
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b0;
            done_d    = 1'b0;
            ack_err_d = 1'b0;
            timeout_d = 1'b1;
        end else begin
            timeout_d = 1'b0;
        end
        ready_d = (state_d == S_IDLE);
    end

    // State, counters, synchronizers and registered outputs.
    always_ff @(posedge ck) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ph_cnt_q   <= '0;
            to_cnt_q   <= '0;
            bit_idx_q  <= 4'd0;
            frame_q    <= 10'd0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_prev_q <= 1'b0;
            dat_s1_q   <= 1'b0;
            dat_s2_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            to_cnt_q   <= to_cnt_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
        end
    end

    assign tx_ready   = ready_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = (state_q != S_IDLE);
    assign tx_done    = done_q;
    assign tx_ack_err = ack_err_q;
    assign tx_timeout = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of the host
// and compares the received bits, timing and status pulses against expectations built from the byte.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int STH = 4;
    localparam int TO  = 2000;

    logic       ck = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       busy, tx_done, tx_ack_err, tx_timeout;
    logic       dev_clk_low, dev_dat_low;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   to_cnt   = 0;
    logic [3:0] snap = 4'd0;

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_HOLD_CYCLES(STH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ck(ck), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe), .busy(busy), .tx_done(tx_done), .tx_ack_err(tx_ack_err),
        .tx_timeout(tx_timeout)
    );

    always #5 ck = ~ck;

    // Running tallies of status pulses plus a snapshot taken at each completion pulse.
    always @(negedge ck) begin
        if (tx_done)    done_cnt <= done_cnt + 1;
        if (tx_ack_err) err_cnt  <= err_cnt + 1;
        if (tx_timeout) to_cnt   <= to_cnt + 1;
        if (tx_done || tx_ack_err) snap <= {tx_ready, ps2_clk_oe, ps2_dat_oe, busy};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic accept(input logic [7:0] b, input bit keep_valid);
        int g;
        g = 0;
        while (!tx_ready && g < 100) begin cycles(1); g++; end
        chk("ready_before_accept", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        cycles(1);
        chk("accept_latency", {ps2_clk_oe, busy, tx_ready}, 3'b110);
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    // Device side of one frame; abort_at >= 0 drops reset during that bit's low phase.
    task automatic run_frame(input logic [7:0] b, input bit ack_low, input bit check_inh, input int abort_at);
        logic [9:0] exp_bits, got;
        int ones, g, n, d0, e0, t0;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        exp_bits = {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
        got = 10'd0;
        d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
        g = 0;
        while (!ps2_clk_oe && g < 50) begin cycles(1); g++; end
        chk("clk_oe_up", ps2_clk_oe, 1);
        n = 0; g = 0;
        while (ps2_clk_oe && !ps2_dat_oe && g < 4 * INH) begin n++; g++; cycles(1); end
        if (check_inh) chk("inhibit_len", n, INH);
        chk("ready_while_busy", tx_ready, 0);
        n = 0; g = 0;
        while (ps2_clk_oe && ps2_dat_oe && g < 50) begin n++; g++; cycles(1); end
        chk("start_len", n, STH);
        chk("start_bit", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ack_low) dev_dat_low = 1'b1;
            cycles(8);
            dev_clk_low = 1'b1;
            cycles(10);
            if (i == abort_at) begin
                reset = 1'b0;
                cycles(1);
                chk("reset_mid_frame", {ps2_clk_oe, ps2_dat_oe, busy, tx_ready}, 4'b0000);
                dev_clk_low = 1'b0;
                cycles(2);
                reset = 1'b1;
                cycles(5);
                return;
            end
            if (i < 10) got[i] = ps2_dat_in;
            dev_clk_low = 1'b0;
        end
        cycles(4);
        dev_dat_low = 1'b0;
        g = 0;
        while ((done_cnt - d0) + (err_cnt - e0) == 0 && g < 60) begin cycles(1); g++; end
        cycles(3);
        chk("frame_bits", got, exp_bits);
        chk("parity_bit", got[8], exp_bits[8]);
        chk("done_pulses", done_cnt - d0, ack_low ? 1 : 0);
        chk("ack_err_pulses", err_cnt - e0, ack_low ? 0 : 1);
        chk("no_timeout", to_cnt - t0, 0);
        chk("end_state", snap, 4'b1000);
    endtask

    initial begin
        int g, n, d0, e0;
        reset = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        cycles(3);
        chk("reset_outputs", {ps2_clk_oe, ps2_dat_oe, tx_ready, busy, tx_done, tx_ack_err, tx_timeout}, 7'd0);
        reset = 1'b1;
        cycles(1);
        chk("ready_after_reset", tx_ready, 1);
        cycles(4);

        // Directed frames including both parity polarities.
        accept(8'hED, 1'b0); run_frame(8'hED, 1'b1, 1'b1, -1);
        accept(8'h01, 1'b0); run_frame(8'h01, 1'b1, 1'b1, -1);
        accept(8'h00, 1'b0); run_frame(8'h00, 1'b1, 1'b1, -1);

        // Device leaves data high in the ACK slot.
        accept(8'h5C, 1'b0); run_frame(8'h5C, 1'b0, 1'b1, -1);
        chk("ack_err_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);

        // Device never clocks: expect abort after TO cycles of SEND.
        d0 = done_cnt; e0 = err_cnt;
        accept(8'h3C, 1'b0);
        g = 0;
        while ((ps2_clk_oe || !busy) && g < 100) begin cycles(1); g++; end
        tx_valid = 1'b1;
        n = 0;
        while (busy && n < TO + 1000) begin n++; cycles(1); end
        tx_valid = 1'b0;
        chk("timeout_len", n, TO);
        chk("timeout_pulse", tx_timeout, 1);
        chk("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        cycles(3);
        chk("timeout_no_done", (done_cnt - d0) + (err_cnt - e0), 0);

        // Reset mid-transfer, then a clean frame.
        accept(8'h96, 1'b0); run_frame(8'h96, 1'b1, 1'b1, 4);
        accept(8'hAA, 1'b0); run_frame(8'hAA, 1'b1, 1'b1, -1);

        // Reset coincident with an accept drops the byte.
        tx_data = 8'h77; tx_valid = 1'b1; reset = 1'b0;
        cycles(1);
        tx_valid = 1'b0; reset = 1'b1;
        cycles(3);
        chk("reset_beats_accept", {busy, ps2_clk_oe}, 2'b00);

        // Two queued bytes with tx_valid held high throughout the first frame.
        accept(8'hC3, 1'b1);
        tx_data = 8'h18;
        run_frame(8'hC3, 1'b1, 1'b1, -1);
        tx_valid = 1'b0;
        chk("second_accepted", {busy, ps2_clk_oe}, 2'b11);
        run_frame(8'h18, 1'b1, 1'b0, -1);

        // Random bytes.
        for (int k = 0; k < 4; k++) begin
            logic [7:0] rb;
            rb = 8'($urandom_range(0, 255));
            accept(rb, 1'b0);
            run_frame(rb, 1'b1, 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
